// File: rtl/multi_clock_divider.sv
// multi_clock_divider: per-channel programmable 50% clock divider with tick and one-shot outputs
module multi_clock_divider #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 32,
  parameter int DEFAULT_DIV = 25_000_000,
  localparam int CIDX = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic [CHANNELS-1:0] mode,
  input  logic                wr_en,
  input  logic [CIDX-1:0]     wr_chan,
  input  logic [WIDTH-1:0]    wr_div,
  output logic [CHANNELS-1:0] clock_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d, a_q, a_d, c_q, c_d;
    logic out_q, out_d, tick_q, tick_d, done_q, done_d, mode_q, mode_d;
    logic wr_hit, bnd;
    // s_d feeds a_d so a write landing on a boundary governs the next half-period
    always_comb begin
      wr_hit = wr_en && (wr_chan == CIDX'(g));
      s_d = wr_hit ? ((wr_div == '0) ? WIDTH'(1) : wr_div) : s_q;
      bnd = (state_q == RUN) && (c_q == a_q - WIDTH'(1));
      a_d = (state_q != RUN || bnd) ? s_d : a_q;
      mode_d = (state_q == IDLE) ? mode[g] : mode_q;
      state_d = state_q;
      c_d = '0;
      out_d = 1'b0;
      tick_d = 1'b0;
      done_d = 1'b0;
      if (enable[g]) begin
        case (state_q)
          IDLE: state_d = RUN;
          RUN: begin
            c_d = bnd ? '0 : c_q + WIDTH'(1);
            out_d = bnd ? ~out_q : out_q;
            tick_d = bnd & ~out_q;
            done_d = bnd & out_q & mode_q;
            state_d = (bnd & out_q & mode_q) ? DONE : RUN;
          end
          DONE: done_d = 1'b1;
          default: state_d = IDLE;
        endcase
      end else begin
        state_d = IDLE;
      end
    end
    always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        s_q <= WIDTH'(DEFAULT_DIV);
        a_q <= WIDTH'(DEFAULT_DIV);
        c_q <= '0;
        out_q <= 1'b0;
        tick_q <= 1'b0;
        done_q <= 1'b0;
        mode_q <= 1'b0;
      end else begin
        state_q <= state_d;
        s_q <= s_d;
        a_q <= a_d;
        c_q <= c_d;
        out_q <= out_d;
        tick_q <= tick_d;
        done_q <= done_d;
        mode_q <= mode_d;
      end
    end
    assign clock_out[g] = out_q;
    assign tick[g] = tick_q;
    assign done[g] = done_q;
  end
endmodule

// File: tb/tb_multi_clock_divider.sv
// tb_multi_clock_divider: timestamp-based reference model plus directed literal checks
module tb_multi_clock_divider;
  localparam int CH = 3;
  localparam int W = 8;
  localparam int DEF = 3;
  logic clock_in = 1'b0;
  logic reset = 1'b1;
  logic [CH-1:0] enable = '0;
  logic [CH-1:0] mode = '0;
  logic wr_en = 1'b0;
  logic [1:0] wr_chan = '0;
  logic [W-1:0] wr_div = '0;
  logic [CH-1:0] clock_out, tick, done;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  multi_clock_divider #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clock_in(clock_in), .reset(reset), .enable(enable), .mode(mode),
    .wr_en(wr_en), .wr_chan(wr_chan), .wr_div(wr_div),
    .clock_out(clock_out), .tick(tick), .done(done)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  // Model: each half-period length is the shadow value at the edge where it begins
  int cyc;
  int sh [CH];
  int nxt [CH];
  bit run [CH], dn [CH], lvl [CH], tk [CH], one [CH];
  always @(posedge clock_in or posedge reset) begin
    if (reset) begin
      cyc = 0;
      for (int i = 0; i < CH; i++) begin
        sh[i] = DEF; nxt[i] = 0; run[i] = 0; dn[i] = 0; lvl[i] = 0; tk[i] = 0; one[i] = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < CH; i++) begin
        int ns;
        ns = sh[i];
        if (wr_en && wr_chan == i) ns = (wr_div == 0) ? 1 : int'(wr_div);
        tk[i] = 0;
        if (!enable[i]) begin
          run[i] = 0; dn[i] = 0; lvl[i] = 0;
        end else if (!run[i] && !dn[i]) begin
          run[i] = 1; one[i] = mode[i]; nxt[i] = cyc + ns;
        end else if (run[i] && cyc == nxt[i]) begin
          lvl[i] = !lvl[i];
          tk[i] = lvl[i];
          if (!lvl[i] && one[i]) begin
            run[i] = 0; dn[i] = 1;
          end else begin
            nxt[i] = cyc + ns;
          end
        end
        sh[i] = ns;
      end
    end
  end

  always @(negedge clock_in) begin
    if (chk_en)
      for (int i = 0; i < CH; i++)
        chk($sformatf("model_ch%0d", i), {29'd0, clock_out[i], tick[i], done[i]},
            {29'd0, lvl[i], tk[i], dn[i]});
  end

  initial begin
    step(3);
    chk("reset_clock_out", {29'd0, clock_out}, 0);
    chk("reset_tick_done", {26'd0, tick, done}, 0);
    reset = 1'b0;
    chk_en = 1'b1;
    // free-run ch0, default half-period 3
    enable = 3'b001;
    step(3);  chk("ch0_low_e2", {31'd0, clock_out[0]}, 0);
    step(1);  chk("ch0_rise_e3", {30'd0, clock_out[0], tick[0]}, 2'b11);
    step(3);  chk("ch0_fall_e6", {31'd0, clock_out[0]}, 0);
    step(3);  chk("ch0_tick_e9", {30'd0, clock_out[0], tick[0]}, 2'b11);
    chk("ch1_idle", {31'd0, clock_out[1]}, 0);
    // mid half-period write of 5
    wr_en = 1'b1; wr_chan = 2'd0; wr_div = 8'd5;
    step(1);
    wr_en = 1'b0;
    step(2);  chk("ch0_fall_e12_old_a", {31'd0, clock_out[0]}, 0);
    step(4);  chk("ch0_low_e16", {31'd0, clock_out[0]}, 0);
    step(1);  chk("ch0_rise_e17_new_a", {30'd0, clock_out[0], tick[0]}, 2'b11);
    // write landing on the boundary at e22
    step(4);
    wr_en = 1'b1; wr_div = 8'd2;
    step(1);  chk("ch0_fall_e22", {31'd0, clock_out[0]}, 0);
    wr_en = 1'b0;
    step(1);  chk("ch0_low_e23", {31'd0, clock_out[0]}, 0);
    step(1);  chk("ch0_rise_e24_bypass", {30'd0, clock_out[0], tick[0]}, 2'b11);
    // divisor 0 on ch1 behaves as 1
    wr_en = 1'b1; wr_chan = 2'd1; wr_div = 8'd0;
    step(1);
    wr_en = 1'b0; enable = 3'b011;
    step(2);  chk("ch1_div0_rise", {30'd0, clock_out[1], tick[1]}, 2'b11);
    step(1);  chk("ch1_div0_fall", {30'd0, clock_out[1], tick[1]}, 2'b00);
    step(1);  chk("ch1_div0_rise2", {30'd0, clock_out[1], tick[1]}, 2'b11);
    // invalid channel write must leave every divisor alone
    wr_en = 1'b1; wr_chan = 2'd3; wr_div = 8'd7;
    step(1);
    wr_en = 1'b0; enable = 3'b111;
    step(3);  chk("ch2_low_after_bad_wr", {31'd0, clock_out[2]}, 0);
    step(1);  chk("ch2_rise_default", {30'd0, clock_out[2], tick[2]}, 2'b11);
    // one-shot on ch1, half-period 2
    enable = 3'b101; wr_en = 1'b1; wr_chan = 2'd1; wr_div = 8'd2; mode = 3'b010;
    step(1);  chk("ch1_idle_outputs", {29'd0, clock_out[1], tick[1], done[1]}, 0);
    wr_en = 1'b0; enable = 3'b111;
    step(2);  chk("os_low_k1", {31'd0, clock_out[1]}, 0);
    step(1);  chk("os_rise_k2", {30'd0, clock_out[1], tick[1]}, 2'b11);
    step(1);  chk("os_high_k3", {30'd0, clock_out[1], tick[1]}, 2'b10);
    step(1);  chk("os_done_k4", {30'd0, clock_out[1], done[1]}, 2'b01);
    step(3);  chk("os_done_hold", {29'd0, clock_out[1], tick[1], done[1]}, 3'b001);
    enable = 3'b101;
    step(1);  chk("os_done_clear", {31'd0, done[1]}, 0);
    enable = 3'b111;
    step(3);  chk("os_repulse", {31'd0, clock_out[1]}, 1);
    step(2);  chk("os_redone", {31'd0, done[1]}, 1);
    // enable dropped on the edge a boundary is due
    enable = 3'b110;
    step(1);
    enable = 3'b111;
    step(2);
    enable = 3'b110;
    step(1);  chk("drop_on_boundary", {30'd0, clock_out[0], tick[0]}, 2'b00);
    step(2);  chk("drop_stays_low", {31'd0, clock_out[0]}, 0);
    // asynchronous reset mid-run
    enable = 3'b111; mode = 3'b000;
    step(3);  chk("pre_reset_high", {31'd0, clock_out[0]}, 1);
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", {23'd0, clock_out, tick, done}, 0);
    @(negedge clock_in);
    enable = 3'b001;
    reset = 1'b0;
    step(3);  chk("post_reset_low_e2", {31'd0, clock_out[0]}, 0);
    step(1);  chk("post_reset_rise_e3", {30'd0, clock_out[0], tick[0]}, 2'b11);
    step(2);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
